// File: rtl/sequencer_if.sv
// Control-line bundle between the sequencer (master) and the sysbus datapath (slave).
// Carries the IR opcode and ALU zero flag inward; all strobes, halted and instr_count outward.
interface sequencer_if #(
    parameter int OP_W = 3
);
    logic [OP_W-1:0] opcode;
    logic            z_flag;

    logic            ACC_bus;
    logic            load_ACC;
    logic            PC_bus;
    logic            load_PC;
    logic            load_IR;
    logic            load_MAR;
    logic            MDR_bus;
    logic            ALU_ACC;
    logic            ALU_add;
    logic            ALU_sub;
    logic            ALU_xor;
    logic            INC_PC;
    logic            Addr_bus;
    logic            CS;
    logic            R_NW;
    logic            halted;
    logic [15:0]     instr_count;

    modport master (
        input  opcode, z_flag,
        output ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus,
               ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW,
               halted, instr_count
    );

    modport slave (
        output opcode, z_flag,
        input  ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus,
               ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW,
               halted, instr_count
    );
endinterface

// File: rtl/sequencer.sv
// Fetch/decode/execute control sequencer for the 8-bit sysbus processor.
// Define SEQ_HALT_EN to make opcode 111 a HALT; otherwise it decodes as NOP.
module sequencer (
    input  logic        clock,
    input  logic        n_reset,
    sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_IR,
        S_ADDR,
        S_EXEC,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_BNE   = 3'b100,
        OP_XOR   = 3'b101,
        OP_NOP   = 3'b110,
        OP_HALT  = 3'b111
    } op_e;

    typedef struct packed {
        logic acc_bus;
        logic load_acc;
        logic pc_bus;
        logic load_pc;
        logic load_ir;
        logic load_mar;
        logic mdr_bus;
        logic alu_acc;
        logic alu_add;
        logic alu_sub;
        logic alu_xor;
        logic inc_pc;
        logic addr_bus;
        logic cs;
        logic r_nw;
        logic halted;
    } ctrl_t;

    state_e      state_q;
    state_e      state_d;
    logic [15:0] count_q;
    logic        count_en;
    ctrl_t       ctrl;
    op_e         op;

    assign op = op_e'(bus.opcode);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (count_en && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        ctrl      = '0;
        ctrl.r_nw = 1'b1;

        unique case (state_q)
            S_FETCH: begin
                ctrl.pc_bus   = 1'b1;
                ctrl.load_mar = 1'b1;
                ctrl.inc_pc   = 1'b1;
                ctrl.load_pc  = 1'b1;
                state_d       = S_IR;
            end
            S_IR: begin
                ctrl.cs      = 1'b1;
                ctrl.mdr_bus = 1'b1;
                ctrl.load_ir = 1'b1;
                state_d      = S_ADDR;
            end
            S_ADDR: begin
                state_d = S_FETCH;
                case (op)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_XOR: begin
                        ctrl.addr_bus = 1'b1;
                        ctrl.load_mar = 1'b1;
                        state_d       = S_EXEC;
                    end
                    OP_BNE: begin
                        // Branch target goes straight from the IR address field into the PC.
                        ctrl.addr_bus = 1'b1;
                        ctrl.load_pc  = !bus.z_flag;
                    end
                    OP_HALT: begin
`ifdef SEQ_HALT_EN
                        state_d = S_HALT;
`endif
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_LOAD: begin
                        ctrl.cs       = 1'b1;
                        ctrl.mdr_bus  = 1'b1;
                        ctrl.load_acc = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_XOR: begin
                        ctrl.cs       = 1'b1;
                        ctrl.mdr_bus  = 1'b1;
                        ctrl.load_acc = 1'b1;
                        ctrl.alu_acc  = 1'b1;
                        ctrl.alu_add  = (op == OP_ADD);
                        ctrl.alu_sub  = (op == OP_SUB);
                        ctrl.alu_xor  = (op == OP_XOR);
                    end
                    OP_STORE: begin
                        ctrl.cs      = 1'b1;
                        ctrl.acc_bus = 1'b1;
                        ctrl.r_nw    = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
`ifdef SEQ_HALT_EN
                ctrl.halted = 1'b1;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase

        count_en = (state_d == S_FETCH) &&
                   ((state_q == S_ADDR) || (state_q == S_EXEC));

        // Outputs fall to their idle values the moment reset asserts, not at the next edge.
        if (!n_reset) begin
            ctrl      = '0;
            ctrl.r_nw = 1'b1;
        end
    end

    assign bus.ACC_bus     = ctrl.acc_bus;
    assign bus.load_ACC    = ctrl.load_acc;
    assign bus.PC_bus      = ctrl.pc_bus;
    assign bus.load_PC     = ctrl.load_pc;
    assign bus.load_IR     = ctrl.load_ir;
    assign bus.load_MAR    = ctrl.load_mar;
    assign bus.MDR_bus     = ctrl.mdr_bus;
    assign bus.ALU_ACC     = ctrl.alu_acc;
    assign bus.ALU_add     = ctrl.alu_add;
    assign bus.ALU_sub     = ctrl.alu_sub;
    assign bus.ALU_xor     = ctrl.alu_xor;
    assign bus.INC_PC      = ctrl.inc_pc;
    assign bus.Addr_bus    = ctrl.addr_bus;
    assign bus.CS          = ctrl.cs;
    assign bus.R_NW        = ctrl.r_nw;
    assign bus.halted      = ctrl.halted;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the sequencer: per-cycle strobe vectors, instruction count,
// asynchronous reset and count saturation (opcode 111 follows SEQ_HALT_EN).
module tb_sequencer;

    localparam logic [15:0] B_ACC_BUS  = 16'h8000;
    localparam logic [15:0] B_LOAD_ACC = 16'h4000;
    localparam logic [15:0] B_PC_BUS   = 16'h2000;
    localparam logic [15:0] B_LOAD_PC  = 16'h1000;
    localparam logic [15:0] B_LOAD_IR  = 16'h0800;
    localparam logic [15:0] B_LOAD_MAR = 16'h0400;
    localparam logic [15:0] B_MDR_BUS  = 16'h0200;
    localparam logic [15:0] B_ALU_ACC  = 16'h0100;
    localparam logic [15:0] B_ALU_ADD  = 16'h0080;
    localparam logic [15:0] B_ALU_SUB  = 16'h0040;
    localparam logic [15:0] B_ALU_XOR  = 16'h0020;
    localparam logic [15:0] B_INC_PC   = 16'h0010;
    localparam logic [15:0] B_ADDR_BUS = 16'h0008;
    localparam logic [15:0] B_CS       = 16'h0004;
    localparam logic [15:0] B_R_NW     = 16'h0002;
    localparam logic [15:0] B_HALTED   = 16'h0001;

    localparam logic [15:0] V_RST   = B_R_NW;
    localparam logic [15:0] V_FETCH = B_PC_BUS | B_LOAD_MAR | B_INC_PC | B_LOAD_PC | B_R_NW;
    localparam logic [15:0] V_IR    = B_CS | B_MDR_BUS | B_LOAD_IR | B_R_NW;
    localparam logic [15:0] V_ADDR  = B_ADDR_BUS | B_LOAD_MAR | B_R_NW;
    localparam logic [15:0] V_LOAD  = B_CS | B_MDR_BUS | B_LOAD_ACC | B_R_NW;
    localparam logic [15:0] V_ADD   = V_LOAD | B_ALU_ACC | B_ALU_ADD;
    localparam logic [15:0] V_SUB   = V_LOAD | B_ALU_ACC | B_ALU_SUB;
    localparam logic [15:0] V_XOR   = V_LOAD | B_ALU_ACC | B_ALU_XOR;
    localparam logic [15:0] V_STORE = B_CS | B_ACC_BUS;
    localparam logic [15:0] V_BNE_T = B_ADDR_BUS | B_LOAD_PC | B_R_NW;
    localparam logic [15:0] V_BNE_N = B_ADDR_BUS | B_R_NW;
    localparam logic [15:0] V_IDLE  = B_R_NW;
    localparam logic [15:0] V_HALT  = B_R_NW | B_HALTED;

    logic        clock;
    logic        n_reset;
    logic [15:0] obs;
    logic [15:0] exp_count;
    int          total;
    int          errs;

    sequencer_if #(.OP_W(3)) bus ();

    sequencer dut (
        .clock   (clock),
        .n_reset (n_reset),
        .bus     (bus.master)
    );

    assign obs = {bus.ACC_bus, bus.load_ACC, bus.PC_bus, bus.load_PC, bus.load_IR,
                  bus.load_MAR, bus.MDR_bus, bus.ALU_ACC, bus.ALU_add, bus.ALU_sub,
                  bus.ALU_xor, bus.INC_PC, bus.Addr_bus, bus.CS, bus.R_NW, bus.halted};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        assert (got === want)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic bump();
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    endtask

    // Four-cycle instruction; starts and ends in the S_FETCH cycle.
    task automatic instr4(input string tag, input logic [2:0] op, input logic [15:0] v_exec);
        bus.opcode = op;
        check({tag, " fetch"}, obs, V_FETCH);
        step();
        check({tag, " ir"}, obs, V_IR);
        step();
        check({tag, " addr"}, obs, V_ADDR);
        step();
        check({tag, " exec"}, obs, v_exec);
        step();
        bump();
        check({tag, " count"}, bus.instr_count, exp_count);
    endtask

    // Three-cycle instruction (BNE, NOP); starts and ends in the S_FETCH cycle.
    task automatic instr3(input string tag, input logic [2:0] op, input logic z,
                          input logic [15:0] v_addr);
        bus.opcode = op;
        bus.z_flag = z;
        check({tag, " fetch"}, obs, V_FETCH);
        step();
        check({tag, " ir"}, obs, V_IR);
        step();
        check({tag, " addr"}, obs, v_addr);
        step();
        bump();
        check({tag, " count"}, bus.instr_count, exp_count);
    endtask

    // Asynchronous reset pulse, checked before any clock edge, then release into S_FETCH.
    task automatic reset_pulse(input string tag);
        n_reset = 1'b0;
        #1;
        check({tag, " async outputs"}, obs, V_RST);
        check({tag, " async count"}, bus.instr_count, 16'h0000);
        step();
        step();
        n_reset = 1'b1;
        exp_count = 16'h0000;
        #1;
        check({tag, " restart fetch"}, obs, V_FETCH);
        check({tag, " restart count"}, bus.instr_count, exp_count);
    endtask

    initial begin
        total      = 0;
        errs       = 0;
        exp_count  = 16'h0000;
        n_reset    = 1'b0;
        bus.opcode = 3'b000;
        bus.z_flag = 1'b0;

        step();
        step();
        check("reset outputs", obs, V_RST);
        check("reset count", bus.instr_count, 16'h0000);

        n_reset = 1'b1;
        #1;

        instr4("load", 3'b000, V_LOAD);
        instr4("add", 3'b010, V_ADD);
        check("count after 8 cycles", bus.instr_count, 16'd2);
        instr4("store", 3'b001, V_STORE);
        instr3("bne z0", 3'b100, 1'b0, V_BNE_T);
        instr3("bne z1", 3'b100, 1'b1, V_BNE_N);
        instr4("sub", 3'b011, V_SUB);
        instr4("xor", 3'b101, V_XOR);
        instr3("nop", 3'b110, 1'b0, V_IDLE);

`ifdef SEQ_HALT_EN
        bus.opcode = 3'b111;
        check("halt fetch", obs, V_FETCH);
        step();
        check("halt ir", obs, V_IR);
        step();
        check("halt addr", obs, V_IDLE);
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt hold", obs, V_HALT);
            check("halt count", bus.instr_count, exp_count);
        end
        reset_pulse("halt exit");
`else
        instr3("op111 as nop", 3'b111, 1'b0, V_IDLE);
`endif

        // Reset pulled low during S_EXEC of an ADD.
        bus.opcode = 3'b010;
        check("rst-add fetch", obs, V_FETCH);
        step();
        check("rst-add ir", obs, V_IR);
        step();
        check("rst-add addr", obs, V_ADDR);
        step();
        check("rst-add exec", obs, V_ADD);
        #1;
        reset_pulse("mid-add reset");

        // Preload the counter just below saturation, then retire NOPs.
        bus.opcode = 3'b110;
        force dut.count_q = 16'hFFFC;
        step();
        release dut.count_q;
        step();
        step();
        exp_count = 16'hFFFD;
        check("sat preload", bus.instr_count, exp_count);
        for (int i = 0; i < 4; i++) begin
            instr3("sat nop", 3'b110, 1'b0, V_IDLE);
        end
        check("sat final", bus.instr_count, 16'hFFFF);

        $display("%0d/%0d checks passed", total - errs, total);
        $finish;
    end

endmodule
